// File: rtl/t05_status_display_if.sv
// Status display bus: controller/override inputs toward the display block and
// the code/request/ack handshake with the display driver.
//   cont_state  controller state (4 bits)
//   ext_code    external override code
//   ext_sel     selects ext_code over the mapped controller state
//   err_clr     request to clear the sticky error
//   disp_ack    acknowledge from the display driver
//   disp_code   code presented to the driver
//   disp_req    update request to the driver
//   err_sticky  latched error flag
//   blank       blink blanking for the display
interface t05_status_display_if #(
  parameter int unsigned CODE_W = 4
);
  logic [3:0]        cont_state;
  logic [CODE_W-1:0] ext_code;
  logic              ext_sel;
  logic              err_clr;
  logic              disp_ack;
  logic [CODE_W-1:0] disp_code;
  logic              disp_req;
  logic              err_sticky;
  logic              blank;

  // Display block side
  modport master (
    input  cont_state, ext_code, ext_sel, err_clr, disp_ack,
    output disp_code, disp_req, err_sticky, blank
  );

  // Driver / controller side
  modport slave (
    output cont_state, ext_code, ext_sel, err_clr, disp_ack,
    input  disp_code, disp_req, err_sticky, blank
  );
endinterface

// File: rtl/t05_status_display.sv
// Status display arbiter: maps the controller state (or an external override)
// to a display code, hands it to the driver with a req/ack handshake, holds
// each acknowledged code for a minimum dwell, latches errors and blinks the
// display while an error code is shown.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  t05_status_display_if.master (see interface for signal list)
module t05_status_display #(
  parameter int unsigned CODE_W       = 4,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLINK_CYCLES = 500
) (
  input  logic                          clk,
  input  logic                          rst,
  t05_status_display_if.master          bus
);

  localparam int unsigned DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [CODE_W-1:0] CODE_ERR   = CODE_W'(7);
  localparam logic [DW_W-1:0]   DWELL_LOAD = DW_W'(DWELL_CYCLES - 1);
  localparam logic [BL_W-1:0]   BLINK_LAST = BL_W'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

  // Registered input copies
  logic [3:0]        cs_q;
  logic [CODE_W-1:0] ext_code_q;
  logic              ext_sel_q;
  logic              err_clr_q;
  logic              ack_q;

  logic [CODE_W-1:0] mapped_c;
  logic [CODE_W-1:0] cand_c;
  logic              err_set_c;
  logic              err_sticky_q;

  state_t            state_q, state_n;
  logic [CODE_W-1:0] code_q, code_n;
  logic              req_q, req_n;
  logic [DW_W-1:0]   dwell_q, dwell_n;

  logic [BL_W-1:0]   blink_cnt_q;
  logic              blank_q;

  // Input stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q       <= '0;
      ext_code_q <= '0;
      ext_sel_q  <= 1'b0;
      err_clr_q  <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      cs_q       <= bus.cont_state;
      ext_code_q <= bus.ext_code;
      ext_sel_q  <= bus.ext_sel;
      err_clr_q  <= bus.err_clr;
      ack_q      <= bus.disp_ack;
    end
  end

  // Controller state to code; out-of-range states count as ERROR
  always_comb begin
    mapped_c = CODE_W'(cs_q);
    if (cs_q > 4'd8) begin
      mapped_c = CODE_ERR;
    end
  end

  assign err_set_c = (mapped_c == CODE_ERR);

  // Sticky error: set beats clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
    end else if (err_set_c) begin
      err_sticky_q <= 1'b1;
    end else if (err_clr_q) begin
      err_sticky_q <= 1'b0;
    end
  end

  // Candidate priority: sticky error, then override, then controller state
  always_comb begin
    cand_c = mapped_c;
    if (err_sticky_q) begin
      cand_c = CODE_ERR;
    end else if (ext_sel_q) begin
      cand_c = ext_code_q;
    end
  end

  // Handshake FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WAIT;
      code_q  <= '0;
      req_q   <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_n;
      code_q  <= code_n;
      req_q   <= req_n;
      dwell_q <= dwell_n;
    end
  end

  // Handshake FSM next state
  always_comb begin
    state_n = state_q;
    code_n  = code_q;
    req_n   = req_q;
    dwell_n = dwell_q;
    unique case (state_q)
      ST_WAIT: begin
        if (cand_c != code_q) begin
          code_n  = cand_c;
          req_n   = 1'b1;
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        // Never aborted; only the driver's ack moves on
        if (ack_q) begin
          req_n   = 1'b0;
          dwell_n = DWELL_LOAD;
          state_n = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if ((cand_c == CODE_ERR) && (code_q != CODE_ERR)) begin
          // Error preempts the remaining dwell
          state_n = ST_WAIT;
        end else if (dwell_q <= DW_W'(1)) begin
          // Leave on the edge the counter reaches 0
          dwell_n = '0;
          state_n = ST_WAIT;
        end else begin
          dwell_n = dwell_q - 1'b1;
        end
      end
      default: begin
        state_n = ST_WAIT;
        req_n   = 1'b0;
      end
    endcase
  end

  // Blink generator, runs only while an error code is on the display
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else if (err_sticky_q && (code_q == CODE_ERR)) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        blank_q     <= ~blank_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end else begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end
  end

  assign bus.disp_code  = code_q;
  assign bus.disp_req   = req_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.blank      = blank_q;

endmodule

// File: tb/tb_t05_status_display.sv
// Bench for t05_status_display: directed scenarios, a timeline-based reference
// model compared every cycle, and hand-computed literal checkpoints.
module tb_t05_status_display;

  localparam int unsigned CODE_W = 4;
  localparam int DWELL = 8;
  localparam int BLINK = 4;

  logic clk;
  logic rst;

  t05_status_display_if #(.CODE_W(CODE_W)) bus ();

  t05_status_display #(
    .CODE_W      (CODE_W),
    .DWELL_CYCLES(DWELL),
    .BLINK_CYCLES(BLINK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: inputs seen one edge late; a new code may be taken once
  // the edge index reaches free_at, which an ack pushes DWELL edges out.
  logic [3:0] r_cs, r_ext;
  logic       r_sel, r_clr, r_ack;
  int         m_n, m_free, m_code, m_bcnt;
  logic       m_req, m_err, m_blank;

  int         t_mapped, t_cand, t_code, t_free, t_bcnt;
  logic       t_err, t_req, t_blank;

  always_comb begin
    t_mapped = (int'(r_cs) <= 8) ? int'(r_cs) : 7;
    t_cand   = m_err ? 7 : (r_sel ? int'(r_ext) : t_mapped);
    t_err    = (t_mapped == 7) ? 1'b1 : (r_clr ? 1'b0 : m_err);
    t_code   = m_code;
    t_req    = m_req;
    t_free   = m_free;
    if (m_req) begin
      if (r_ack) begin
        t_req  = 1'b0;
        t_free = m_n + DWELL;
      end
    end else if (m_n >= m_free) begin
      if (t_cand != m_code) begin
        t_code = t_cand;
        t_req  = 1'b1;
      end
    end else if (t_cand == 7 && m_code != 7) begin
      t_free = m_n + 1;
    end
    t_bcnt  = 0;
    t_blank = 1'b0;
    if (m_err && m_code == 7) begin
      if (m_bcnt + 1 == BLINK) begin
        t_bcnt  = 0;
        t_blank = ~m_blank;
      end else begin
        t_bcnt  = m_bcnt + 1;
        t_blank = m_blank;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs <= '0; r_ext <= '0; r_sel <= 1'b0; r_clr <= 1'b0; r_ack <= 1'b0;
      m_n <= 0; m_free <= 0; m_code <= 0; m_bcnt <= 0;
      m_req <= 1'b0; m_err <= 1'b0; m_blank <= 1'b0;
    end else begin
      r_cs <= bus.cont_state; r_ext <= bus.ext_code; r_sel <= bus.ext_sel;
      r_clr <= bus.err_clr; r_ack <= bus.disp_ack;
      m_n <= m_n + 1; m_free <= t_free; m_code <= t_code; m_bcnt <= t_bcnt;
      m_req <= t_req; m_err <= t_err; m_blank <= t_blank;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("model_disp_code", int'(bus.disp_code), m_code);
      chk("model_disp_req", int'(bus.disp_req), int'(m_req));
      chk("model_err_sticky", int'(bus.err_sticky), int'(m_err));
      chk("model_blank", int'(bus.blank), int'(m_blank));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_now();
    bus.disp_ack = 1'b1;
    @(negedge clk);
    bus.disp_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_req(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.disp_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, int'(seen), 1);
  endtask

  initial begin
    logic prev;
    logic found;
    int   per;

    rst = 1'b1;
    bus.cont_state = '0; bus.ext_code = '0; bus.ext_sel = 1'b0;
    bus.err_clr = 1'b0; bus.disp_ack = 1'b0;
    cyc(3);
    chk("rst_code", int'(bus.disp_code), 0);
    chk("rst_req", int'(bus.disp_req), 0);
    chk("rst_err", int'(bus.err_sticky), 0);
    chk("rst_blank", int'(bus.blank), 0);
    rst = 1'b0;
    cyc(1);

    // 0 -> 1: request two edges after the change
    bus.cont_state = 4'd1;
    cyc(1);
    chk("req_not_yet", int'(bus.disp_req), 0);
    cyc(1);
    chk("code1", int'(bus.disp_code), 1);
    chk("req1", int'(bus.disp_req), 1);
    cyc(3);
    bus.disp_ack = 1'b1;
    cyc(1);
    bus.disp_ack = 1'b0;
    chk("req_held_ack_edge", int'(bus.disp_req), 1);
    cyc(1);
    chk("req_dropped", int'(bus.disp_req), 0);

    // 1 -> 2 -> 3 during dwell: 2 skipped, 3 exactly DWELL after ack
    bus.cont_state = 4'd2;
    cyc(1);
    bus.cont_state = 4'd3;
    cyc(6);
    chk("dwell_hold_req", int'(bus.disp_req), 0);
    chk("dwell_hold_code", int'(bus.disp_code), 1);
    cyc(1);
    chk("code3", int'(bus.disp_code), 3);
    chk("req3", int'(bus.disp_req), 1);
    ack_now();

    // Error preempts dwell of code 4
    bus.cont_state = 4'd4;
    wait_req("req_code4");
    chk("code4", int'(bus.disp_code), 4);
    ack_now();
    cyc(2);
    bus.cont_state = 4'd7;
    cyc(3);
    chk("err_code", int'(bus.disp_code), 7);
    chk("err_req", int'(bus.disp_req), 1);
    chk("err_sticky_set", int'(bus.err_sticky), 1);
    ack_now();

    // Blink half period
    prev = bus.blank;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.blank != prev) begin
        found = 1'b1;
        break;
      end
    end
    chk("blink_start", int'(found), 1);
    prev = bus.blank;
    per = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      per++;
      if (bus.blank != prev) break;
    end
    chk("blink_period", per, BLINK);

    // Clear refused while still in error, accepted once state leaves it
    bus.err_clr = 1'b1;
    cyc(3);
    chk("clr_refused", int'(bus.err_sticky), 1);
    bus.cont_state = 4'd0;
    cyc(2);
    chk("clr_accepted", int'(bus.err_sticky), 0);
    bus.err_clr = 1'b0;
    wait_req("req_code0");
    chk("code0", int'(bus.disp_code), 0);
    ack_now();

    // Override, then out-of-range state forces ERROR over it
    bus.ext_sel = 1'b1;
    bus.ext_code = 4'd9;
    wait_req("req_ext9");
    chk("code_ext9", int'(bus.disp_code), 9);
    ack_now();
    cyc(10);
    bus.cont_state = 4'd12;
    wait_req("req_err12");
    chk("code_err12", int'(bus.disp_code), 7);
    chk("err_state12", int'(bus.err_sticky), 1);
    ack_now();

    // Reset during an open request
    bus.ext_sel = 1'b0;
    bus.cont_state = 4'd5;
    bus.err_clr = 1'b1;
    wait_req("req_code5");
    chk("code5", int'(bus.disp_code), 5);
    #2;
    rst = 1'b1;
    #1;
    chk("async_code", int'(bus.disp_code), 0);
    chk("async_req", int'(bus.disp_req), 0);
    chk("async_err", int'(bus.err_sticky), 0);
    chk("async_blank", int'(bus.blank), 0);
    bus.cont_state = 4'd0;
    bus.err_clr = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    // Ack while idle is ignored
    bus.disp_ack = 1'b1;
    cyc(1);
    bus.disp_ack = 1'b0;
    cyc(12);
    chk("post_rst_no_req", int'(bus.disp_req), 0);
    chk("post_rst_code", int'(bus.disp_code), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
